byte_word_packer: RTL and testbench

- Downstream stage of the registered 8-bit byte source; packs a byte stream into WORD_BYTES-wide words for the wrapper's word-level sink.
- Valid/ready handshake on both sides; a packet terminator (input_last) flushes a partial word.
- Holds one output word, applies backpressure upstream, and keeps a wrapping word counter for debug.

---
 rtl/byte_word_packer.sv | 110 +++++++++++
 tb/tb_byte_word_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs an 8-bit byte stream into WORD_BYTES-wide words.
// Bytes fill lanes little-endian. A word closes on its last lane or on
// input_last, and it is then held in a single output register until it is
// accepted downstream.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid must not depend on ready. A source holds its data stable while
// valid is high and ready is low.
module byte_word_packer #(
    parameter int DATA_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              input_valid,
    output logic                              input_ready,
    input  logic [DATA_W-1:0]                 input_data,
    input  logic                              input_last,
    output logic                              output_valid,
    input  logic                              output_ready,
    output logic [DATA_W*WORD_BYTES-1:0]      output_word,
    output logic [$clog2(WORD_BYTES+1)-1:0]   output_count,
    output logic                              output_last,
    output logic [CNT_W-1:0]                  words_sent,
    output logic [0:0]                        debug_state
);

    localparam int WORD_W   = DATA_W * WORD_BYTES;
    localparam int IDX_W    = $clog2(WORD_BYTES);
    localparam int CNT_BITS = $clog2(WORD_BYTES + 1);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [0:0]        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_with_byte;
    logic              byte_accept;
    logic              out_accept;
    logic              word_close;

    // A held word blocks new bytes unless it drains in this same cycle.
    assign output_valid = (state_q == HOLD);
    assign input_ready  = !output_valid || output_ready;
    assign byte_accept  = input_valid && input_ready;
    assign out_accept   = output_valid && output_ready;
    assign word_close   = byte_accept && ((idx_q == LAST_IDX) || input_last);
    assign debug_state  = state_q;

    // Accumulator with the incoming byte merged into the current lane. Lanes
    // above idx are still zero because the accumulator clears on every close.
    always_comb begin
        acc_with_byte = acc_q;
        acc_with_byte[idx_q*DATA_W +: DATA_W] = input_data;
    end

    // Control FSM. A closing byte takes priority and keeps HOLD, so a word
    // draining and a new word closing in the same cycle leave no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
        end else if (word_close) begin
            state_q <= HOLD;
        end else if (out_accept) begin
            state_q <= COLLECT;
        end
    end

    // Lane index and accumulator. They clear when a word closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (word_close) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (byte_accept) begin
            idx_q <= idx_q + IDX_W'(1);
            acc_q <= acc_with_byte;
        end
    end

    // Output holding register. It loads only on close, so it stays stable
    // while the word waits for downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            output_word  <= '0;
            output_count <= '0;
            output_last  <= 1'b0;
        end else if (word_close) begin
            output_word  <= acc_with_byte;
            output_count <= CNT_BITS'(idx_q) + CNT_BITS'(1);
            output_last  <= input_last;
        end
    end

    // Wrapping count of words accepted downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_sent <= '0;
        end else if (out_accept) begin
            words_sent <= words_sent + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer. A reference model watches the input
// handshake, queues each expected word, and compares it when the word is
// accepted downstream.
module tb_byte_word_packer;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  count;
    logic        last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        input_valid;
  logic        input_ready;
  logic [7:0]  input_data;
  logic        input_last;
  logic        output_valid;
  logic        output_ready;
  logic [31:0] output_word;
  logic [2:0]  output_count;
  logic        output_last;
  logic [15:0] words_sent;
  logic [0:0]  debug_state;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] m_acc;
  int          m_idx;
  logic        m_hold;
  logic [15:0] m_words;

  byte_word_packer #(.DATA_W(8), .WORD_BYTES(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .input_last   (input_last),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_word  (output_word),
    .output_count (output_count),
    .output_last  (output_last),
    .words_sent   (words_sent),
    .debug_state  (debug_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard / reference model, evaluated on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ready;
      logic out_acc;
      logic byte_acc;
      logic close;
      exp_t e;
      exp_ready = !m_hold || output_ready;
      check("input_ready", input_ready, exp_ready);
      check("output_valid", output_valid, m_hold);
      check("words_sent", words_sent, m_words);
      if (reset) begin
        exp_q.delete();
        m_acc = '0;
        m_idx = 0;
        m_hold = 1'b0;
        m_words = '0;
      end else begin
        out_acc = m_hold && output_ready;
        byte_acc = input_valid && exp_ready;
        close = 1'b0;
        if (out_acc) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("output_word", output_word, e.word);
            check("output_count", output_count, e.count);
            check("output_last", output_last, e.last);
          end
          m_words = m_words + 16'd1;
        end
        if (byte_acc) begin
          m_acc[m_idx*8 +: 8] = input_data;
          if (m_idx == 3 || input_last) begin
            e.word = m_acc;
            e.count = 3'(m_idx + 1);
            e.last = input_last;
            exp_q.push_back(e);
            m_acc = '0;
            m_idx = 0;
            close = 1'b1;
          end else begin
            m_idx++;
          end
        end
        if (close) m_hold = 1'b1;
        else if (out_acc) m_hold = 1'b0;
      end
    end
  end

  // driver: present one byte and wait (bounded) until it is accepted
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    logic acc;
    input_valid = 1'b1;
    input_data = d;
    input_last = l;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = input_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    input_valid = 1'b0;
    input_data = 'x;
    input_last = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    input_valid = 1'b0;
    input_data = '0;
    input_last = 1'b0;
    output_ready = 1'b0;
    m_acc = '0;
    m_idx = 0;
    m_hold = 1'b0;
    m_words = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", output_valid, 0);
    check("rst_ready", input_ready, 1);
    check("rst_word", output_word, 0);
    check("rst_count", output_count, 0);
    check("rst_last", output_last, 0);
    check("rst_words_sent", words_sent, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // full word, drained immediately
    output_ready = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check("t1_valid", output_valid, 1);
    check("t1_word", output_word, 32'h44332211);
    check("t1_count", output_count, 4);
    check("t1_last", output_last, 0);
    @(posedge clk);
    #1;
    check("t1_valid_one_cycle", output_valid, 0);
    check("t1_words_sent", words_sent, 1);

    // partial word flushed by last
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    check("t2_word", output_word, 32'h0000BBAA);
    check("t2_count", output_count, 2);
    check("t2_last", output_last, 1);
    @(posedge clk);
    #1;

    // downstream stall with upstream still presenting a byte
    output_ready = 1'b0;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b0);
    input_valid = 1'b1;
    input_data = 8'hD1;
    input_last = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("t3_stall_ready", input_ready, 0);
      check("t3_stall_valid", output_valid, 1);
      check("t3_stall_word", output_word, 32'hC4C3C2C1);
    end
    output_ready = 1'b1;
    #1;
    check("t3_ready_release", input_ready, 1);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    input_data = 'x;
    check("t3_valid_drop", output_valid, 0);
    send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'hD4, 1'b0);
    check("t3_next_word", output_word, 32'hD4D3D2D1);
    @(posedge clk);
    #1;

    // back-to-back stream, fresh counter
    pulse_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    check("t4_word0", output_word, 32'h04030201);
    for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b0);
    check("t4_word1", output_word, 32'h08070605);
    check("t4_valid", output_valid, 1);
    @(posedge clk);
    #1;
    check("t4_words_sent", words_sent, 2);

    // reset mid-word discards partial lanes
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    pulse_reset();
    check("t5_valid_after_reset", output_valid, 0);
    check("t5_words_sent_reset", words_sent, 0);
    send_byte(8'h55, 1'b1);
    check("t5_word", output_word, 32'h00000055);
    check("t5_count", output_count, 1);
    check("t5_last", output_last, 1);
    @(posedge clk);
    #1;

    // counter wrap: words_sent is 1 here
    for (int i = 0; i < 65534; i++) send_byte(8'(i), 1'b1);
    @(posedge clk);
    #1;
    check("t6_words_sent_max", words_sent, 16'hFFFF);
    send_byte(8'h99, 1'b1);
    @(posedge clk);
    #1;
    check("t6_words_sent_wrap", words_sent, 16'h0000);
    check("end_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
